cache_arbiter: RTL
==================

Name: cache_arbiter

Overview:
- Sits directly downstream of the split L1 caches (I-cache and D-cache datapath/control pairs) and upstream of the unified L2 cache.
- Accepts 128-bit line-fill reads from both L1s and dirty-line write-backs from the D-cache.
- Arbitrates them onto the single L2 port and returns the L2 response to the granted requester.
- All transfers are whole 16-byte lines; the L2 port matches the L1 physical-memory side one-for-one.

Parameters:
ADDR_W, 16, byte address width (lc3b_word)
LINE_W, 128, cache line width in bits
RR_EN, 1, 1 = round-robin between I and D on a tie; 0 = fixed D-cache priority

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
i_read  in  1  I-cache line-fill request, held until i_resp
i_address  in  ADDR_W  I-cache line address (bits [3:0] ignored)
i_rdata  out  LINE_W  fill data to I-cache
i_resp  out  1  one-cycle completion pulse to I-cache
d_read  in  1  D-cache line-fill request, held until d_resp
d_write  in  1  D-cache write-back request, held until d_resp
d_address  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  write-back line
d_rdata  out  LINE_W  fill data to D-cache
d_resp  out  1  one-cycle completion pulse to D-cache
l2_read  out  1  read strobe to L2, held until l2_resp
l2_write  out  1  write strobe to L2, held until l2_resp
l2_address  out  ADDR_W  line address to L2, bits [3:0] forced to 0
l2_wdata  out  LINE_W  write-back data to L2
l2_rdata  in  LINE_W  L2 read data, valid with l2_resp
l2_resp  in  1  L2 completion pulse

Behaviour:
- Clocking: the single clk domain, rising edge. rst_n is sampled only at clk edges (synchronous, active-low).
- FSM states: IDLE, SERVE_I, SERVE_D, DONE.
- Reset (rst_n=0 at an edge):
  - state to IDLE; last_grant to D, so I wins the first tie when RR_EN=1.
  - Latched address, wdata and op registers cleared to 0.
  - All outputs 0: l2_read, l2_write, i_resp, d_resp, l2_address, l2_wdata, i_rdata, d_rdata.
- IDLE:
  - i_req = i_read; d_req = d_read | d_write.
  - Only one requester active: grant it.
  - Both active: RR_EN=1 grants the side not equal to last_grant; RR_EN=0 grants D.
  - On a grant edge: latch the address (low 4 bits zeroed), d_wdata and the op; set last_grant; go to SERVE_I or SERVE_D.
  - No request: stay in IDLE.
- d_read and d_write both high is a D-cache protocol violation; the arbiter treats it as a write.
- SERVE_x:
  - l2_read or l2_write is asserted from the latched op (registered; first asserted the cycle after the grant edge).
  - l2_address and l2_wdata come from the latched registers, stable for the whole transaction regardless of requester input changes.
  - When l2_resp=1 in SERVE_I: i_resp=1 combinationally in the same cycle, and i_rdata=l2_rdata. SERVE_D drives d_resp and d_rdata the same way; d_rdata is a don't-care on writes but still passes l2_rdata.
  - Next edge: go to DONE, deassert the L2 strobes.
- DONE:
  - Exactly one cycle; no grant is made.
  - Lets the requester drop its held request, so a stale request is never re-granted.
  - Then go to IDLE.
- resp pulses:
  - Never asserted outside SERVE_x.
  - Never asserted to the non-granted side.
  - Length is exactly the length of the l2_resp pulse.
- i_rdata and d_rdata hold their last value (registered copy, captured on resp) when not responding.
- Minimum latency:
  - Request at edge N is granted at N, and the L2 strobe is high in cycle N+1.
  - With L2 responding in that cycle, resp is seen in cycle N+1.
  - A new request is accepted at edge N+3.
- l2_resp in IDLE or DONE (spurious or post-reset): ignored, no resp generated.
- Reset mid-transaction: abort to IDLE immediately; L2 strobes low the cycle after the reset edge. The L2 and L1s are reset together, so there is no recovery handshake.
- Requester drops its request while in SERVE_x: the transaction still completes to L2, and resp is still pulsed.
- Starvation bound with RR_EN=1: a continuously asserted request is granted within one competing transaction.

Test Plan:
- Reset, then i_read=1, i_address=16'h1236, L2 responding 3 cycles later with l2_rdata=128'hA5...A5 → l2_read=1, l2_address=16'h1230 for 3 cycles; i_resp one cycle with i_rdata=A5..A5; d_resp stays 0.
- d_write=1, d_address=16'h80F0, d_wdata=128'h0123..CDEF → l2_write=1, l2_address=16'h80F0, l2_wdata=0123..CDEF held until l2_resp; d_resp one cycle; then DONE; IDLE.
- i_read and d_read raised on the same edge, RR_EN=1, first tie after reset → I served first, D next; repeating the tie alternates D, I. With RR_EN=0, D is served every time.
- Change d_address to 16'hFFFF mid-SERVE_D → l2_address remains the latched 16'h4000 until l2_resp.
- Assert rst_n=0 during SERVE_I, then l2_resp=1 two cycles later → l2_read low after the reset edge; no i_resp; state IDLE.
- Requester holds i_read one extra cycle after i_resp → no second l2_read (DONE blocks); a new l2_read occurs only if i_read is still high in IDLE.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// L1-to-L2 line-transfer bundle: I-cache fill, D-cache fill/write-back, unified L2 port.
// The slave view belongs to the arbiter; the master view is the surrounding caches.
interface cache_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, l2_rdata, l2_resp,
    output i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_address, l2_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, l2_rdata, l2_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_address, l2_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/write-backs onto one L2 line port.
// One transaction at a time; a DONE cycle separates transactions so held requests drop.
module cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter bit RR_EN  = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  cache_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_e;

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(4'hF);

  state_e            state_q, state_d;
  logic              last_d_q, last_d_d;   // 1: most recent grant went to D
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

  logic i_req, d_req, grant_i, grant_d;
  logic i_resp, d_resp;

  always_comb begin
    i_req   = bus.i_read;
    d_req   = bus.d_read | bus.d_write;
    // On a tie RR_EN hands the grant to whoever did not win last time.
    grant_i = i_req & (~d_req | (RR_EN & last_d_q));
    grant_d = d_req & ~grant_i;
  end

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_resp    = 1'b0;
    d_resp    = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_i || grant_d) begin
          addr_d   = (grant_i ? bus.i_address : bus.d_address) & LINE_MASK;
          wdata_d  = bus.d_wdata;
          // read+write together from D is a protocol error; write wins.
          wr_d     = grant_d & bus.d_write;
          last_d_d = grant_d;
          state_d  = grant_i ? SERVE_I : SERVE_D;
        end
      end
      SERVE_I: begin
        if (bus.l2_resp) begin
          i_resp    = 1'b1;
          i_rdata_d = bus.l2_rdata;
          state_d   = DONE;
        end
      end
      SERVE_D: begin
        if (bus.l2_resp) begin
          d_resp    = 1'b1;
          d_rdata_d = bus.l2_rdata;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b1;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  logic serving;
  assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);

  // Strobes and bus come only from registers, so they are steady across the transaction.
  assign bus.l2_read    = serving & ~wr_q;
  assign bus.l2_write   = serving & wr_q;
  assign bus.l2_address = addr_q;
  assign bus.l2_wdata   = wdata_q;

  // The _d copies pass l2_rdata through in the response cycle and hold otherwise.
  assign bus.i_resp  = i_resp;
  assign bus.d_resp  = d_resp;
  assign bus.i_rdata = i_rdata_d;
  assign bus.d_rdata = d_rdata_d;

endmodule
